// File: rtl/shift_serializer.sv
// Parallel-to-serial converter: LANES lanes of BITS-bit words shifted out
// one bit per clock, with selectable bit order and gapless back-to-back words.
module shift_serializer #(
  parameter int unsigned BITS  = 6,
  parameter int unsigned LANES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BITS*LANES-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  msb_first,
  output logic [LANES-1:0]      q,
  output logic                  q_valid,
  output logic                  sos,
  output logic                  eos,
  output logic                  busy
);

  localparam int unsigned CW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                       state, state_d;
  logic [CW-1:0]                count, count_d;
  logic [LANES-1:0][BITS-1:0]   shadow, shadow_d;
  logic                         mode, mode_d;
  logic                         last_c;
  logic                         xfer_c;
  logic [CW-1:0]                idx_c;

  // Ready depends only on registered state so the source sees no valid->ready loop.
  assign last_c    = (state == SHIFT) && (count == LAST);
  assign din_ready = (state == IDLE) || last_c;
  assign xfer_c    = din_valid && din_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      shadow <= '0;
      mode   <= 1'b0;
    end else begin
      state  <= state_d;
      count  <= count_d;
      shadow <= shadow_d;
      mode   <= mode_d;
    end
  end

  always_comb begin
    state_d  = state;
    count_d  = count;
    shadow_d = shadow;
    mode_d   = mode;
    case (state)
      IDLE: begin
        if (xfer_c) begin
          shadow_d = din;
          mode_d   = msb_first;
          count_d  = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (last_c) begin
          count_d = '0;
          if (xfer_c) begin
            shadow_d = din;
            mode_d   = msb_first;
          end else begin
            state_d = IDLE;
          end
        end else begin
          count_d = count + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Serial outputs are pure decodes of registered state; no din->q path.
  always_comb begin
    idx_c   = mode ? (LAST - count) : count;
    q_valid = (state == SHIFT);
    sos     = q_valid && (count == '0);
    eos     = last_c;
    busy    = q_valid;
    q       = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      q[l] = q_valid & shadow[l][idx_c];
    end
  end

endmodule

// File: tb/tb_shift_serializer.sv
// Directed self-checking bench for shift_serializer in three configurations.
module tb_shift_serializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  // BITS=6, LANES=1
  logic [5:0] din6 = '0;
  logic       v6 = 1'b0, m6 = 1'b0;
  logic       rdy6, qv6, sos6, eos6, busy6;
  logic [0:0] q6;
  logic [5:0] obs6;
  assign obs6 = {q6, qv6, sos6, eos6, busy6, rdy6};

  // BITS=4, LANES=2
  logic [7:0] din4 = '0;
  logic       v4 = 1'b0, m4 = 1'b0;
  logic       rdy4, qv4, sos4, eos4, busy4;
  logic [1:0] q4;
  logic [6:0] obs4;
  assign obs4 = {q4, qv4, sos4, eos4, busy4, rdy4};

  // BITS=1, LANES=3
  logic [2:0] din1 = '0;
  logic       v1 = 1'b0, m1 = 1'b0;
  logic       rdy1, qv1, sos1, eos1, busy1;
  logic [2:0] q1;
  logic [7:0] obs1;
  assign obs1 = {q1, qv1, sos1, eos1, busy1, rdy1};

  shift_serializer #(.BITS(6), .LANES(1)) u6 (
    .clk(clk), .rst(rst), .din(din6), .din_valid(v6), .din_ready(rdy6),
    .msb_first(m6), .q(q6), .q_valid(qv6), .sos(sos6), .eos(eos6), .busy(busy6)
  );

  shift_serializer #(.BITS(4), .LANES(2)) u4 (
    .clk(clk), .rst(rst), .din(din4), .din_valid(v4), .din_ready(rdy4),
    .msb_first(m4), .q(q4), .q_valid(qv4), .sos(sos4), .eos(eos4), .busy(busy4)
  );

  shift_serializer #(.BITS(1), .LANES(3)) u1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(v1), .din_ready(rdy1),
    .msb_first(m1), .q(q1), .q_valid(qv1), .sos(sos1), .eos(eos1), .busy(busy1)
  );

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (obs6[5:1] !== 5'b00000) begin
      errors++; $display("FAIL reset_u6: got %b want 00000", obs6[5:1]);
    end
    vectors++;
    if (obs4[6:1] !== 6'b000000) begin
      errors++; $display("FAIL reset_u4: got %b want 000000", obs4[6:1]);
    end
    vectors++;
    if (obs1[7:1] !== 7'b0000000) begin
      errors++; $display("FAIL reset_u1: got %b want 0000000", obs1[7:1]);
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({obs6, obs4, obs1} !== {6'b000001, 7'b0000001, 8'b00000001}) begin
        errors++;
        $display("FAIL idle cycle %0d: got %b_%b_%b want 000001_0000001_00000001",
                 i, obs6, obs4, obs1);
      end
    end
  endtask

  task automatic test_lsb_single();
    logic [5:0] seq;
    logic [5:0] exp;
    seq  = 6'b101100;
    din6 = 6'b101100; m6 = 1'b0; v6 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        v6 = 1'b0; din6 = 6'b010011; m6 = 1'b1;
      end
      exp = {seq[i], 1'b1, (i == 0), (i == 5), 1'b1, (i == 5)};
      vectors++;
      if (obs6 !== exp) begin
        errors++; $display("FAIL lsb_single cycle %0d: got %b want %b", i + 1, obs6, exp);
      end
    end
    @(negedge clk);
    vectors++;
    if (obs6 !== 6'b000001) begin
      errors++; $display("FAIL lsb_single_end: got %b want 000001", obs6);
    end
  endtask

  task automatic test_msb_multilane();
    logic [1:0] seq [4];
    logic [6:0] exp;
    seq  = '{2'b10, 2'b01, 2'b10, 2'b01};
    din4 = 8'hA5; m4 = 1'b1; v4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        v4 = 1'b0; din4 = 8'h0F; m4 = 1'b0;
      end
      exp = {seq[i], 1'b1, (i == 0), (i == 3), 1'b1, (i == 3)};
      vectors++;
      if (obs4 !== exp) begin
        errors++; $display("FAIL msb_multilane cycle %0d: got %b want %b", i + 1, obs4, exp);
      end
    end
    @(negedge clk);
    vectors++;
    if (obs4 !== 7'b0000001) begin
      errors++; $display("FAIL msb_multilane_end: got %b want 0000001", obs4);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] seq;
    logic [5:0]  exp;
    logic        edge_bit;
    seq  = 12'h555;
    din6 = 6'h15; m6 = 1'b0; v6 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin
        din6 = 6'h2A; m6 = 1'b1;
      end
      if (i == 11) v6 = 1'b0;
      edge_bit = (i == 5) || (i == 11);
      exp = {seq[i], 1'b1, (i == 0) || (i == 6), edge_bit, 1'b1, edge_bit};
      vectors++;
      if (obs6 !== exp) begin
        errors++; $display("FAIL back_to_back cycle %0d: got %b want %b", i + 1, obs6, exp);
      end
    end
    @(negedge clk);
    vectors++;
    if (obs6 !== 6'b000001) begin
      errors++; $display("FAIL back_to_back_end: got %b want 000001", obs6);
    end
  endtask

  task automatic test_reset_midword();
    logic [5:0] seq;
    logic [5:0] exp;
    seq  = 6'b010111;
    din6 = 6'b010111; m6 = 1'b0; v6 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) v6 = 1'b0;
      exp = {seq[i], 1'b1, (i == 0), 1'b0, 1'b1, 1'b0};
      vectors++;
      if (obs6 !== exp) begin
        errors++; $display("FAIL midword cycle %0d: got %b want %b", i + 1, obs6, exp);
      end
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (obs6 !== 6'b000001) begin
      errors++; $display("FAIL midword_async: got %b want 000001", obs6);
    end
    @(negedge clk);
    vectors++;
    if (obs6 !== 6'b000001) begin
      errors++; $display("FAIL midword_held: got %b want 000001", obs6);
    end
    rst = 1'b1;
    din6 = 6'h3F; m6 = 1'b0; v6 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) v6 = 1'b0;
      exp = {1'b1, 1'b1, (i == 0), (i == 5), 1'b1, (i == 5)};
      vectors++;
      if (obs6 !== exp) begin
        errors++; $display("FAIL after_reset cycle %0d: got %b want %b", i + 1, obs6, exp);
      end
    end
    @(negedge clk);
    vectors++;
    if (obs6 !== 6'b000001) begin
      errors++; $display("FAIL after_reset_end: got %b want 000001", obs6);
    end
  endtask

  task automatic test_bits1();
    logic [2:0] w [5];
    logic [7:0] exp;
    w = '{3'b101, 3'b010, 3'b111, 3'b001, 3'b110};
    vectors++;
    if (rdy1 !== 1'b1) begin
      errors++; $display("FAIL bits1_ready_idle: got %b want 1", rdy1);
    end
    din1 = w[0]; m1 = 1'b1; v1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp = {w[k], 5'b11111};
      vectors++;
      if (obs1 !== exp) begin
        errors++; $display("FAIL bits1 word %0d: got %b want %b", k, obs1, exp);
      end
      if (k < 4) begin
        din1 = w[k + 1]; m1 = ~m1;
      end else begin
        v1 = 1'b0;
      end
    end
    @(negedge clk);
    vectors++;
    if (obs1 !== 8'b00000001) begin
      errors++; $display("FAIL bits1_end: got %b want 00000001", obs1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lsb_single();
    test_msb_multilane();
    test_back_to_back();
    test_reset_midword();
    test_bits1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
